// File: rtl/byte_stream_arbiter.sv
// Round-robin, message-granular arbiter sharing one 8-bit valid/ready byte stream
// between N requesters; a grant lasts until a last-byte handshake or an idle timeout.
module byte_stream_arbiter #(
    parameter int N       = 4,
    parameter int CHW     = (N > 1) ? $clog2(N) : 1,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [8*N-1:0]   req_data,
    input  logic [N-1:0]     req_last,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_last,
    output logic [CHW-1:0]   grant_chan,
    output logic             busy,
    output logic             timeout_pulse
);

    localparam int CNTW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q;
    logic [CHW-1:0]    ptr_q;
    logic [CHW-1:0]    grant_q;
    logic [CNTW-1:0]   idle_cnt_q;
    logic              timeout_q;

    logic [CHW-1:0]    grant_d;
    logic              win_found;
    logic [7:0]        data_arr [N];
    logic              cur_valid;
    logic              cur_last;

    function automatic logic [CHW-1:0] wrap_idx(input logic [CHW-1:0] base, input int unsigned off);
        int unsigned s;
        s = (32'(base) + off) % N;
        return s[CHW-1:0];
    endfunction

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign data_arr[i] = req_data[8*i +: 8];
    end

    // Scan from the channel after the last owner so the previous owner ranks lowest.
    always_comb begin
        win_found = 1'b0;
        grant_d   = '0;
        for (int i = 1; i <= N; i++) begin
            if (!win_found && req_valid[wrap_idx(ptr_q, i)]) begin
                win_found = 1'b1;
                grant_d   = wrap_idx(ptr_q, i);
            end
        end
    end

    assign cur_valid = req_valid[grant_q];
    assign cur_last  = req_last[grant_q];

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= CHW'(N - 1);
            grant_q    <= '0;
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    idle_cnt_q <= '0;
                    if (win_found) begin
                        grant_q <= grant_d;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cur_valid) begin
                        idle_cnt_q <= '0;
                        if (tx_ready && cur_last) begin
                            ptr_q   <= grant_q;
                            state_q <= IDLE;
                        end
                    end else if (TIMEOUT > 0) begin
                        // Only a silent owner ages; downstream back-pressure never does.
                        if (idle_cnt_q == CNTW'(TIMEOUT - 1)) begin
                            timeout_q  <= 1'b1;
                            ptr_q      <= grant_q;
                            idle_cnt_q <= '0;
                            state_q    <= IDLE;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + CNTW'(1);
                        end
                    end else begin
                        idle_cnt_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        tx_last   = 1'b0;
        if (state_q == BUSY) begin
            req_ready[grant_q] = tx_ready;
            tx_valid           = cur_valid;
            tx_data            = data_arr[grant_q];
            tx_last            = cur_last;
        end
    end

    assign busy          = (state_q == BUSY);
    assign grant_chan    = grant_q;
    assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_byte_stream_arbiter.sv
// Directed bench for byte_stream_arbiter (N=4, TIMEOUT=8) with hand-computed expectations.
module tb_byte_stream_arbiter;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic [1:0]  grant_chan;
    logic        busy;
    logic        timeout_pulse;

    logic [7:0]  dat [4];
    int          k [4];
    int          vectors = 0;
    int          miscompares = 0;

    assign req_data = {dat[3], dat[2], dat[1], dat[0]};

    always #5 clk_clk = ~clk_clk;

    byte_stream_arbiter #(.N(4), .TIMEOUT(8)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .req_last      (req_last),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .tx_last       (tx_last),
        .grant_chan    (grant_chan),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Three-byte round-robin requester model: data = 0x10*i + k, last on k==2.
    task automatic drive_rr();
        for (int i = 0; i < 4; i++) begin
            dat[i]       = 8'(16 * i + k[i]);
            req_last[i]  = (k[i] == 2);
            req_valid[i] = (k[i] < 3);
        end
    endtask

    task automatic advance_rr();
        for (int i = 0; i < 4; i++)
            if (req_valid[i] && req_ready[i]) k[i]++;
    endtask

    initial begin
        reset_reset_n = 1'b0;
        req_valid = '0;
        req_last  = '0;
        tx_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dat[i] = 8'h00;
            k[i]   = 0;
        end

        // Reset state
        repeat (2) @(negedge clk_clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_txv", tx_valid, 0);
        chk("rst_rdy", req_ready, 0);
        chk("rst_to", timeout_pulse, 0);
        chk("rst_grant", grant_chan, 0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;

        // Round robin: all four request three-byte messages
        @(negedge clk_clk);
        drive_rr();
        #1;
        chk("rr_idle0", tx_valid, 0);
        for (int m = 0; m < 4; m++) begin
            for (int kk = 0; kk < 3; kk++) begin
                @(negedge clk_clk);
                drive_rr();
                #1;
                chk("rr_txv", tx_valid, 1);
                chk("rr_data", tx_data, 32'(16 * m + kk));
                chk("rr_grant", grant_chan, 32'(m));
                chk("rr_last", tx_last, (kk == 2) ? 1 : 0);
                advance_rr();
            end
            @(negedge clk_clk);
            drive_rr();
            #1;
            chk("rr_gap_busy", busy, 0);
            chk("rr_gap_txv", tx_valid, 0);
        end

        // Owner 1 four bytes under toggling tx_ready, requester 2 waiting
        @(negedge clk_clk);
        req_valid = 4'b0110;
        req_last  = 4'b0000;
        dat[1] = 8'h40;
        dat[2] = 8'h50;
        req_last[2] = 1'b1;
        #1;
        chk("bp_idle", tx_valid, 0);
        k[1] = 0;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk_clk);
            tx_ready = (j % 2 == 0);
            dat[1] = 8'(8'h40 + k[1]);
            req_last[1] = (k[1] == 3);
            #1;
            chk("bp_grant", grant_chan, 1);
            chk("bp_data", tx_data, 32'(8'h40 + (j + 1) / 2));
            chk("bp_last", tx_last, (j >= 5) ? 1 : 0);
            chk("bp_rdy1", req_ready[1], (j % 2 == 0) ? 1 : 0);
            chk("bp_rdy2", req_ready[2], 0);
            if (req_valid[1] && req_ready[1]) k[1]++;
        end
        @(negedge clk_clk);
        tx_ready = 1'b1;
        req_valid[1] = 1'b0;
        #1;
        chk("bp_gap", busy, 0);
        chk("bp_gap_rdy2", req_ready[2], 0);
        @(negedge clk_clk);
        #1;
        chk("bp_g2_grant", grant_chan, 2);
        chk("bp_g2_data", tx_data, 32'h50);
        chk("bp_g2_last", tx_last, 1);
        @(negedge clk_clk);
        req_valid = '0;
        req_last  = '0;
        #1;
        chk("bp_end", busy, 0);

        // Timeout: owner 0 sends one byte without last, then goes silent
        @(negedge clk_clk);
        req_valid[0] = 1'b1;
        dat[0] = 8'h60;
        #1;
        chk("to_idle", busy, 0);
        @(negedge clk_clk);
        #1;
        chk("to_grant", grant_chan, 0);
        chk("to_data", tx_data, 32'h60);
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk_clk);
            req_valid[0] = 1'b0;
            #1;
            chk("to_wait_busy", busy, 1);
            chk("to_wait_pulse", timeout_pulse, 0);
        end
        @(negedge clk_clk);
        req_valid = 4'b0011;
        req_last  = 4'b0011;
        dat[0] = 8'h70;
        dat[1] = 8'h71;
        #1;
        chk("to_pulse", timeout_pulse, 1);
        chk("to_pulse_busy", busy, 0);
        chk("to_pulse_txv", tx_valid, 0);
        @(negedge clk_clk);
        #1;
        chk("to_next_grant", grant_chan, 1);
        chk("to_next_data", tx_data, 32'h71);
        chk("to_pulse_gone", timeout_pulse, 0);
        @(negedge clk_clk);
        req_valid[1] = 1'b0;
        #1;
        chk("to_gap", busy, 0);
        @(negedge clk_clk);
        #1;
        chk("to_g0_grant", grant_chan, 0);
        chk("to_g0_data", tx_data, 32'h70);
        @(negedge clk_clk);
        req_valid = '0;
        req_last  = '0;
        #1;
        chk("to_end", busy, 0);

        // Long back-pressure with valid held never times out
        @(negedge clk_clk);
        req_valid[2] = 1'b1;
        req_last[2]  = 1'b1;
        dat[2] = 8'h80;
        #1;
        chk("st_idle", busy, 0);
        for (int j = 0; j < 50; j++) begin
            @(negedge clk_clk);
            tx_ready = 1'b0;
            #1;
            chk("st_busy", busy, 1);
            chk("st_txv", tx_valid, 1);
            chk("st_pulse", timeout_pulse, 0);
        end
        @(negedge clk_clk);
        tx_ready = 1'b1;
        #1;
        chk("st_grant", grant_chan, 2);
        chk("st_data", tx_data, 32'h80);
        chk("st_rdy", req_ready, 32'h4);
        @(negedge clk_clk);
        req_valid = '0;
        req_last  = '0;
        #1;
        chk("st_end_busy", busy, 0);
        chk("st_end_pulse", timeout_pulse, 0);

        // Back-to-back single-byte messages from requester 3
        for (int j = 0; j < 8; j++) begin
            @(negedge clk_clk);
            req_valid[3] = 1'b1;
            req_last[3]  = 1'b1;
            dat[3] = 8'hA5;
            #1;
            chk("sb_txv", tx_valid, (j % 2 == 1) ? 1 : 0);
            if (j % 2 == 1) begin
                chk("sb_data", tx_data, 32'hA5);
                chk("sb_last", tx_last, 1);
                chk("sb_grant", grant_chan, 3);
            end
        end
        @(negedge clk_clk);
        req_valid = '0;
        req_last  = '0;
        #1;
        chk("sb_end", busy, 0);

        // Asynchronous reset mid-message
        @(negedge clk_clk);
        req_valid[1] = 1'b1;
        dat[1] = 8'h90;
        #1;
        chk("ar_idle", busy, 0);
        @(negedge clk_clk);
        #1;
        chk("ar_grant", grant_chan, 1);
        chk("ar_data", tx_data, 32'h90);
        @(negedge clk_clk);
        dat[1] = 8'h91;
        #1;
        chk("ar_pre_busy", busy, 1);
        reset_reset_n = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_txv", tx_valid, 0);
        chk("ar_rdy", req_ready, 0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        req_valid = 4'b0011;
        req_last[0] = 1'b1;
        dat[0] = 8'h33;
        #1;
        chk("ar_rel_busy", busy, 0);
        @(negedge clk_clk);
        #1;
        chk("ar_first_grant", grant_chan, 0);
        chk("ar_first_data", tx_data, 32'h33);
        @(negedge clk_clk);
        req_valid = '0;
        req_last  = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
